// File: rtl/scalar_decode.sv
// Assembles a little-endian byte stream into an N-bit Ed25519 scalar and flags
// whether it is canonical (< Q). The comparison is resolved incrementally, one byte per accept.
module scalar_decode #(
  parameter int N = 256,
  parameter logic [N-1:0] Q = 256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_scalar,
  output logic         out_canonical,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int NBYTES = N / 8;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lt;
  logic [7:0]    q_byte;
  logic          lt_next;
  logic          accept;
  logic          take;

  // Bytes arrive LSB first, so a later byte decides the order unless it ties,
  // in which case the verdict from the lower bytes carries forward.
  always_comb begin
    q_byte  = Q[cnt*8 +: 8];
    lt_next = (in_data < q_byte) | ((in_data == q_byte) & lt);
    accept  = in_valid & in_ready;
    take    = out_valid & out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= COLLECT;
      cnt           <= '0;
      lt            <= 1'b0;
      out_scalar    <= '0;
      out_canonical <= 1'b0;
      out_valid     <= 1'b0;
      in_ready      <= 1'b0;
    end else if (clr) begin
      state     <= COLLECT;
      cnt       <= '0;
      lt        <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        COLLECT: begin
          in_ready <= 1'b1;
          if (accept) begin
            out_scalar[cnt*8 +: 8] <= in_data;
            lt <= lt_next;
            if (cnt == LAST) begin
              state         <= HOLD;
              out_canonical <= lt_next;
              out_valid     <= 1'b1;
              in_ready      <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          // Result stays put until taken; out_scalar is overwritten lane by lane later.
          if (take) begin
            state     <= COLLECT;
            cnt       <= '0;
            lt        <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_decode.sv
// Table-driven bench for scalar_decode: directed frames with hand-computed results
// plus sequences for backpressure, input gaps, async reset and synchronous abort.
module tb_scalar_decode;

  localparam int NB = 32;
  localparam logic [255:0] Q_VAL     = 256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;
  localparam logic [255:0] QM1_VAL   = 256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ec;
  localparam logic [255:0] FIVE_MEG  = 256'd5000000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] out_scalar;
  logic         out_canonical;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        name;
    logic [255:0] value;
    logic [255:0] exp_scalar;
    logic         exp_canonical;
  } vec_t;

  vec_t vecs[9];

  scalar_decode dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_scalar(out_scalar),
    .out_canonical(out_canonical),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic vec_t makeVec(input string name, input logic [255:0] value,
                                   input logic [255:0] exp_scalar, input logic exp_canonical);
    vec_t v;
    v.name = name;
    v.value = value;
    v.exp_scalar = exp_scalar;
    v.exp_canonical = exp_canonical;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Sends nbytes of value LSB first; leaves the bench at the negedge after the last accept.
  task automatic applyStimulus(input logic [255:0] value, input bit gaps, input int nbytes);
    int guard;
    for (int k = 0; k < nbytes; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 8'($urandom_range(0, 255));
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = value[8*k +: 8];
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL in_ready timeout: got 0 expected 1 at byte %0d", k);
      end
      if (k == NB - 1) checkOutput("out_valid before last byte", 256'(out_valid), 256'd0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic checkResult(input string name, input logic [255:0] exp_scalar, input logic exp_canonical);
    checkOutput({name, " out_valid"}, 256'(out_valid), 256'd1);
    checkOutput({name, " out_scalar"}, out_scalar, exp_scalar);
    checkOutput({name, " out_canonical"}, 256'(out_canonical), 256'(exp_canonical));
  endtask

  task automatic takeResult(input string name, input logic [255:0] exp_scalar, input logic exp_canonical);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({name, " out_valid after take"}, 256'(out_valid), 256'd0);
    checkOutput({name, " in_ready after take"}, 256'(in_ready), 256'd1);
    checkOutput({name, " out_scalar kept"}, out_scalar, exp_scalar);
    checkOutput({name, " out_canonical kept"}, 256'(out_canonical), 256'(exp_canonical));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    vecs[0] = makeVec("five_million", FIVE_MEG, FIVE_MEG, 1'b1);
    vecs[1] = makeVec("equal_q", Q_VAL, Q_VAL, 1'b0);
    vecs[2] = makeVec("q_minus_1", QM1_VAL, QM1_VAL, 1'b1);
    vecs[3] = makeVec("all_ff", {256{1'b1}}, {256{1'b1}}, 1'b0);
    vecs[4] = makeVec("q_plus_256",
                      256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d4ed,
                      256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d4ed, 1'b0);
    vecs[5] = makeVec("q_plus_1",
                      256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ee,
                      256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ee, 1'b0);
    vecs[6] = makeVec("zero", 256'd0, 256'd0, 1'b1);
    vecs[7] = makeVec("two_pow_252",
                      256'h1000000000000000000000000000000000000000000000000000000000000000,
                      256'h1000000000000000000000000000000000000000000000000000000000000000, 1'b1);
    vecs[8] = makeVec("high_byte_wins",
                      256'h1000000000000000000000000000000114def9dea2f79cd65812631a5cf5d300,
                      256'h1000000000000000000000000000000114def9dea2f79cd65812631a5cf5d300, 1'b0);

    #12;
    checkOutput("reset in_ready", 256'(in_ready), 256'd0);
    checkOutput("reset out_valid", 256'(out_valid), 256'd0);
    checkOutput("reset out_scalar", out_scalar, 256'd0);
    checkOutput("reset out_canonical", 256'(out_canonical), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].value, 1'b0, NB);
      checkResult(vecs[i].name, vecs[i].exp_scalar, vecs[i].exp_canonical);
      takeResult(vecs[i].name, vecs[i].exp_scalar, vecs[i].exp_canonical);
    end

    $display("[TB] random in_valid gaps");
    applyStimulus(FIVE_MEG, 1'b1, NB);
    checkResult("gapped five_million", FIVE_MEG, 1'b1);
    takeResult("gapped five_million", FIVE_MEG, 1'b1);
    applyStimulus(QM1_VAL, 1'b1, NB);
    checkResult("gapped q_minus_1", QM1_VAL, 1'b1);
    takeResult("gapped q_minus_1", QM1_VAL, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(Q_VAL, 1'b0, NB);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("backpressure in_ready", 256'(in_ready), 256'd0);
      checkOutput("backpressure out_valid", 256'(out_valid), 256'd1);
      checkOutput("backpressure out_scalar", out_scalar, Q_VAL);
    end
    in_valid = 1'b0;
    checkOutput("backpressure out_canonical", 256'(out_canonical), 256'd0);
    takeResult("backpressure", Q_VAL, 1'b0);
    applyStimulus(FIVE_MEG, 1'b0, NB);
    checkResult("after backpressure", FIVE_MEG, 1'b1);
    takeResult("after backpressure", FIVE_MEG, 1'b1);

    $display("[TB] async reset mid-frame");
    applyStimulus(Q_VAL, 1'b0, 10);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset out_valid", 256'(out_valid), 256'd0);
    checkOutput("mid reset in_ready", 256'(in_ready), 256'd0);
    checkOutput("mid reset out_scalar", out_scalar, 256'd0);
    checkOutput("mid reset out_canonical", 256'(out_canonical), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] clr mid-frame");
    applyStimulus({256{1'b1}}, 1'b0, 20);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk);
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    checkOutput("clr out_valid", 256'(out_valid), 256'd0);
    checkOutput("clr in_ready", 256'(in_ready), 256'd1);
    checkOutput("clr out_scalar kept", out_scalar, (256'd1 << 160) - 256'd1);
    applyStimulus(FIVE_MEG, 1'b0, NB);
    checkResult("after abort", FIVE_MEG, 1'b1);
    takeResult("after abort", FIVE_MEG, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
